// File: rtl/imm_encoder.sv
//------------------------------------------------------------------------------
// imm_encoder
//   Inverse of the datapath immediate generator. Takes a 32-bit two's
//   complement immediate and a format select. It range-checks the immediate and
//   scatters its bits into the immediate fields of an instruction template.
//   Built as a two-stage valid/ready pipeline:
//     - S1 holds the request.
//     - S2 holds the merged instruction and its error flag.
//   The pipeline sustains one transfer per cycle.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : request valid
//   in_ready   : encoder can accept a request this cycle
//   base_inst  : instruction template; its immediate-field bits are ignored
//   imm        : immediate value, two's complement
//   imm_sel    : format select (`Imm_I/`Imm_S/`Imm_B/`Imm_J/`Imm_U)
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
//   out_inst   : encoded instruction
//   out_err    : immediate out of range, misaligned, or unknown select
//   err_cnt    : saturating count of delivered results with out_err=1
//------------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef Imm_I
`define Imm_I 3'd0
`endif
`ifndef Imm_S
`define Imm_S 3'd1
`endif
`ifndef Imm_B
`define Imm_B 3'd2
`endif
`ifndef Imm_J
`define Imm_J 3'd3
`endif
`ifndef Imm_U
`define Imm_U 3'd4
`endif

module imm_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          base_inst,
    input  logic [31:0]          imm,
    input  logic [2:0]           imm_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Immediate does not fit the selected format, is misaligned, or the select is unknown.
    function automatic logic imm_err(input logic [2:0] sel, input logic [31:0] v);
        logic e;
        e = 1'b1;
        case (sel)
            `Imm_I, `Imm_S: e = !((&v[31:11]) || (~|v[31:11]));
            `Imm_B:         e = !((&v[31:12]) || (~|v[31:12])) || v[0];
            `Imm_J:         e = !((&v[31:20]) || (~|v[31:20])) || v[0];
            `Imm_U:         e = |v[11:0];
            default:        e = 1'b1;
        endcase
        return e;
    endfunction

    // Replace the immediate fields of the template with immediate bits. Out-of-range
    // immediates are simply truncated, and an unknown select passes the template through.
    function automatic logic [31:0] imm_merge(input logic [2:0] sel, input logic [31:0] b,
                                              input logic [31:0] v);
        logic [31:0] m;
        m = b;
        case (sel)
            `Imm_I:  m = {v[11:0], b[19:0]};
            `Imm_S:  m = {v[11:5], b[24:12], v[4:0], b[6:0]};
            `Imm_B:  m = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
            `Imm_J:  m = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
            `Imm_U:  m = {v[31:12], b[11:0]};
            default: m = b;
        endcase
        return m;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [31:0]          s1_inst_q,  s1_inst_d;
    logic [31:0]          s1_imm_q,   s1_imm_d;
    logic [2:0]           s1_sel_q,   s1_sel_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_inst_q,  s2_inst_d;
    logic                 s2_err_q,   s2_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic s2_can_load_s;
    logic s1_can_load_s;
    logic out_xfer_s;

    assign out_xfer_s    = s2_valid_q & out_ready;
    assign s2_can_load_s = ~s2_valid_q | out_ready;
    assign s1_can_load_s = ~s1_valid_q | s2_can_load_s;

    assign in_ready  = s1_can_load_s;
    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign err_cnt   = err_cnt_q;

    // Next state for both stages. A stage reloads only when its contents move on or it is empty.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_inst_d  = s1_inst_q;
        s1_imm_d   = s1_imm_q;
        s1_sel_d   = s1_sel_q;
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_can_load_s) begin
            s1_valid_d = in_valid;
            s1_inst_d  = base_inst;
            s1_imm_d   = imm;
            s1_sel_d   = imm_sel;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_can_load_s) begin
            s2_valid_d = s1_valid_q;
            s2_inst_d  = imm_merge(s1_sel_q, s1_inst_q, s1_imm_q);
            s2_err_d   = imm_err(s1_sel_q, s1_imm_q);
        end else begin
            s2_valid_d = s2_valid_q;
        end

        // Count erroneous results as they leave; hold at all-ones.
        if (out_xfer_s && s2_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Pipeline and counter registers. Reset discards any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= 32'h0000_0000;
            s1_imm_q   <= 32'h0000_0000;
            s1_sel_q   <= 3'd0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= 32'h0000_0000;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= {ERR_CNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inst_q  <= s1_inst_d;
            s1_imm_q   <= s1_imm_d;
            s1_sel_q   <= s1_sel_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
`timescale 1ns/1ps

`ifndef Imm_I
`define Imm_I 3'd0
`endif
`ifndef Imm_S
`define Imm_S 3'd1
`endif
`ifndef Imm_B
`define Imm_B 3'd2
`endif
`ifndef Imm_J
`define Imm_J 3'd3
`endif
`ifndef Imm_U
`define Imm_U 3'd4
`endif

module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] base_inst = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [2:0]  imm_sel = 3'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst;
    logic [15:0] err_cnt;
    logic        in_ready4, out_valid4, out_err4;
    logic [31:0] out_inst4;
    logic [3:0]  err_cnt4;

    always #5 clk = ~clk;

    imm_encoder #(.ERR_CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .base_inst(base_inst), .imm(imm), .imm_sel(imm_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .err_cnt(err_cnt));

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    imm_encoder #(.ERR_CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .base_inst(base_inst), .imm(imm), .imm_sel(imm_sel),
        .out_valid(out_valid4), .out_ready(out_ready), .out_inst(out_inst4),
        .out_err(out_err4), .err_cnt(err_cnt4));

    int n_chk = 0;
    int n_pass = 0;
    int exp_cnt = 0;
    int n_out = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [2:0]  sel;
        logic [31:0] imm;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // Which immediate bit lands in instruction bit b for format s (-1: template bit).
    function automatic int imap(input logic [2:0] s, input int b);
        if (s == `Imm_I) return (b >= 20) ? b - 20 : -1;
        if (s == `Imm_S) return (b >= 25) ? b - 20 : ((b >= 7 && b <= 11) ? b - 7 : -1);
        if (s == `Imm_B) begin
            if (b == 31) return 12;
            if (b >= 25) return b - 20;
            if (b >= 8 && b <= 11) return b - 7;
            if (b == 7) return 11;
            return -1;
        end
        if (s == `Imm_J) begin
            if (b == 31) return 20;
            if (b >= 21) return b - 20;
            if (b == 20) return 11;
            if (b >= 12) return b;
            return -1;
        end
        if (s == `Imm_U) return (b >= 12) ? b : -1;
        return -1;
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] b, input logic [2:0] s,
                                               input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) begin
            int m;
            m = imap(s, k);
            r[k] = (m >= 0) ? v[m] : b[k];
        end
        return r;
    endfunction

    // Error judged by numeric range and alignment.
    function automatic logic model_err(input logic [2:0] s, input logic [31:0] v);
        longint x;
        x = longint'($signed(v));
        if (s == `Imm_I || s == `Imm_S) return (x < -2048) || (x > 2047);
        if (s == `Imm_B) return (x < -4096) || (x > 4095) || (x % 2 != 0);
        if (s == `Imm_J) return (x < -(64'sd1 << 20)) || (x >= (64'sd1 << 20)) || (x % 2 != 0);
        if (s == `Imm_U) return (v % 4096) != 0;
        return 1'b1;
    endfunction

    // Decode an instruction back to its sign-extended immediate.
    function automatic logic [31:0] decode(input logic [31:0] ins, input logic [2:0] s);
        logic [31:0] r;
        int top;
        r = 32'h0;
        top = -1;
        for (int k = 0; k < 32; k++) begin
            int m;
            m = imap(s, k);
            if (m >= 0) begin
                r[m] = ins[k];
                if (m > top) top = m;
            end
        end
        if (top >= 0) for (int k = top + 1; k < 32; k++) r[k] = r[top];
        return r;
    endfunction

    // Input monitor: each accepted request pushes its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)
            sb.push_back('{model_inst(base_inst, imm_sel, imm), model_err(imm_sel, imm), imm_sel, imm});
    end

    // Output monitor: each delivered result is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            chk("err_cnt", 32'(err_cnt), exp_cnt);
            chk("err_cnt4", 32'(err_cnt4), (exp_cnt > 15) ? 15 : exp_cnt);
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: got %h with nothing outstanding", out_inst);
            end else begin
                e = sb.pop_front();
                chk("out_inst", out_inst, e.inst);
                chk("out_err", 32'(out_err), 32'(e.err));
                chk("out_inst4", out_inst4, e.inst);
                chk("out_err4", 32'(out_err4), 32'(e.err));
                if (!e.err) chk("roundtrip", decode(out_inst, e.sel), e.imm);
                if (e.err) exp_cnt++;
                n_out++;
            end
        end
    end

    // Random consumer readiness during streaming.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer one request and wait (bounded) until it is accepted; call at posedge+1.
    task automatic send(input logic [31:0] b, input logic [2:0] s, input logic [31:0] v);
        int w;
        in_valid = 1'b1;
        base_inst = b;
        imm_sel = s;
        imm = v;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 300) begin
                n_chk++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", w);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_one(input string name, input logic [31:0] b, input logic [2:0] s,
                            input logic [31:0] v, input logic [31:0] want, input logic werr);
        int lat;
        send(b, s, v);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk({name, "_lat"}, lat, 2);
        chk({name, "_inst"}, out_inst, want);
        chk({name, "_err"}, 32'(out_err), 32'(werr));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", sb.size(), 0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_imm(input logic [2:0] s);
        logic [31:0] r;
        int w;
        r = $urandom;
        if ($urandom_range(0, 2) == 0) return r;
        if (s == `Imm_U) return r & 32'hFFFF_F000;
        w = (s == `Imm_B) ? 13 : (s == `Imm_J) ? 21 : 12;
        r = 32'($signed(r << (32 - w)) >>> (32 - w));
        if (s == `Imm_B || s == `Imm_J) r[0] = 1'b0;
        return r;
    endfunction

    initial begin
        int n0;
        logic [31:0] e0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        send_one("fmt_i", 32'h0000_0013, `Imm_I, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
        send_one("fmt_s", 32'h0000_2023, `Imm_S, 32'h0000_0008, 32'h0000_2423, 1'b0);
        send_one("fmt_b", 32'h0000_0063, `Imm_B, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send_one("fmt_j", 32'h0000_006F, `Imm_J, 32'h0000_0800, 32'h0010_006F, 1'b0);
        send_one("err_u", 32'h0000_0037, `Imm_U, 32'h0000_1001, 32'h0000_1037, 1'b1);
        @(negedge clk);
        chk("err_cnt_one", 32'(err_cnt), 1);
        @(posedge clk);
        #1;
        send_one("err_b", 32'h0000_0063, `Imm_B, 32'h0000_1001, 32'h8000_0063, 1'b1);
        send_one("err_i", 32'h0000_0013, `Imm_I, 32'h0000_0800, 32'h8000_0013, 1'b1);
        send_one("err_sel", 32'h1234_5678, 3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

        // Backpressure: two requests buffer, the third waits.
        out_ready = 1'b0;
        n0 = n_out;
        e0 = model_inst(32'h0000_0013, `Imm_I, 32'h0000_0123);
        in_valid = 1'b1; base_inst = 32'h0000_0013; imm_sel = `Imm_I; imm = 32'h0000_0123;
        @(negedge clk); chk("bp_acc0", 32'(in_ready), 1);
        @(posedge clk); #1 base_inst = 32'h0000_2023; imm_sel = `Imm_S; imm = 32'hFFFF_FF80;
        @(negedge clk); chk("bp_acc1", 32'(in_ready), 1);
        @(posedge clk); #1 base_inst = 32'h0000_0063; imm_sel = `Imm_B; imm = 32'h0000_0FFE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_hold_inst", out_inst, e0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk); chk("bp_acc2", 32'(in_ready), 1);
        @(posedge clk); #1 in_valid = 1'b0;
        drain();
        chk("bp_count", n_out - n0, 3);

        // Streaming with random gaps and random consumer readiness.
        @(posedge clk); #1 rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [2:0] s;
            int r;
            r = $urandom_range(0, 9);
            s = (r < 2) ? `Imm_I : (r < 4) ? `Imm_S : (r < 6) ? `Imm_B : (r < 8) ? `Imm_J :
                (r == 8) ? `Imm_U : 3'($urandom_range(5, 7));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            send($urandom, s, rand_imm(s));
        end
        rand_rdy = 1'b0;
        @(posedge clk); @(posedge clk); #1 out_ready = 1'b1;
        drain();
        chk("stream_err_cnt", 32'(err_cnt), exp_cnt);

        // Saturation of the 4-bit counter.
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) send($urandom, 3'b111, $urandom);
        drain();
        chk("sat_err_cnt4", 32'(err_cnt4), 15);
        chk("sat_err_cnt", 32'(err_cnt), exp_cnt);

        // Reset with both stages full.
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h0000_0013, `Imm_I, 32'h0000_0001);
        send(32'h0000_0013, 3'b111, 32'h0000_0002);
        @(negedge clk);
        chk("full_out_valid", 32'(out_valid), 1);
        chk("full_in_ready", 32'(in_ready), 0);
        #1 rst_n = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 0);
        chk("mid_rst_err_cnt4", 32'(err_cnt4), 0);
        chk("mid_rst_out_inst", out_inst, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        send_one("post_rst", 32'h0000_0013, `Imm_I, 32'h0000_07FF, 32'h7FF0_0013, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the datapath immediate generator: takes a 32-bit immediate and an immediate-format select, range-checks the immediate and scatters its bits into the immediate fields of a supplied instruction template.
- Used by the trace-test stimulus side of the SoC to build instruction words: branch/jump offsets, load/store offsets and LUI/AUIPC constants.
- Two-stage valid/ready pipeline with full throughput, backpressure support and a saturating error counter.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request this cycle.
- base_inst  input  32  instruction template (opcode/rd/rs1/rs2/funct bits); its immediate-field bits are ignored.
- imm  input  32  immediate value, two's complement.
- imm_sel  input  3  format select, using the shared header codes `Imm_I, `Imm_S, `Imm_B, `Imm_J, `Imm_U.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_inst  output  32  encoded instruction.
- out_err  output  1  immediate out of range, misaligned, or imm_sel unknown.
- err_cnt  output  ERR_CNT_W  count of accepted results with out_err=1, saturating.

Behaviour:
- Reset (async, rst_n=0): both stage valids=0, out_valid=0, out_inst=0, out_err=0, err_cnt=0. in_ready=1 after reset releases. An in-flight request is discarded.
- Transfers: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- Stage 1 (S1) registers base_inst, imm and imm_sel, and computes err. Stage 2 (S2) registers the merged instruction and err, and drives out_*.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- Stalls: S2 loads when it is empty or is doing an output transfer this cycle. S1 loads under the same condition on S1. in_ready = !S1_valid | S2_can_load.
- Held data: out_inst and out_err stay stable while out_valid=1 and out_ready=0. With out_ready held low, two requests are buffered and then in_ready=0. No request is lost or duplicated.
- Range checks (err=1 on failure):
  - I: imm[31:11] all equal.
  - S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - Any other imm_sel: err=1 and out_inst=base_inst unchanged.
- Merge: clear the field bits of base_inst, then OR in the immediate bits.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- On err with a known format, the truncated bits are still merged, so the output is deterministic.
- Round-trip property: when out_err=0, decoding out_inst with the matching select returns imm exactly.
- err_cnt increments on each output transfer with out_err=1 and holds at all-ones.
- Simultaneous input and output transfer when full: the pipeline advances by one and stays full, with no bubble.

Test Plan:
- Basic formats, out_ready=1 (expect out_err=0, out_valid 2 cycles after in_valid):
  - base 0x00000013, `Imm_I, imm 0xFFFFFFFF -> out_inst 0xFFF00013.
  - base 0x00002023, `Imm_S, imm 0x8 -> out_inst 0x00002423.
  - base 0x00000063, `Imm_B, imm 0xFFFFFFFC -> out_inst 0xFE000EE3.
  - base 0x0000006F, `Imm_J, imm 0x800 -> out_inst 0x0010006F.
- Error cases:
  - `Imm_U, imm 0x00001001, base 0x00000037 -> out_inst 0x00001037, out_err=1, err_cnt=1.
  - `Imm_B, imm 0x1001 -> out_err=1.
  - `Imm_I, imm 0x800 -> out_err=1.
  - Unknown select 3'b111 -> out_inst=base_inst, out_err=1.
- Backpressure: hold out_ready=0 and offer 3 back-to-back requests -> in_ready=0 after 2 accepted. Then release out_ready -> 3 results delivered in order, no duplicates.
- Streaming: issue 100 random valid requests with in_valid and out_ready toggled randomly -> every result matches the reference decode round-trip, and err_cnt equals the number of erroneous requests.
- Saturation: with ERR_CNT_W=4, send 20 error requests -> err_cnt stops at 15.
- Reset mid-operation: assert rst_n low with both stages full -> out_valid=0, err_cnt=0 immediately, in_ready=1 after release, and the first later request emerges after 2 cycles.
